wb_flag_stage: RTL

- Sits directly downstream of the 16-bit ALU/shifter in the execute path.
- Accepts each ALU result with a valid/ready handshake and holds the condition-code register (S,Z,C,V).
- Evaluates conditional branches against the condition-code register.
- Buffers register-file writebacks in a small FIFO, because the register-file write port is shared and may stall.

---
 rtl/wb_flag_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/wb_flag_stage.sv
// Execute-path back end: accepts ALU beats, keeps the S/Z/C/V condition-code register,
// resolves conditional branches and queues register-file writebacks in a small FIFO.
module wb_flag_stage #(
   parameter int DATA_W = 16,
   parameter int RA_W   = 3,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_res,
   input  logic [3:0]        in_szcv,
   input  logic [RA_W-1:0]   in_rd,
   input  logic              in_wen,
   input  logic              in_setf,
   input  logic              in_br,
   input  logic [2:0]        in_cond,
   input  logic [DATA_W-1:0] in_target,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [RA_W-1:0]   wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [3:0]        flags,
   output logic              br_taken,
   output logic [DATA_W-1:0] br_target
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [RA_W-1:0]   addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [3:0]        flags_q, flags_d;
   logic              br_taken_q, br_taken_d;
   logic [DATA_W-1:0] br_target_q, br_target_d;
   logic              accept;
   logic              push;
   logic              pop;

   function automatic logic cond_met(input logic [2:0] cond, input logic s, input logic z,
                                     input logic v);
      case (cond)
         3'b000:  return z;
         3'b001:  return s ^ v;
         3'b010:  return z | (s ^ v);
         3'b011:  return ~z;
         3'b111:  return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // in_ready depends on registered occupancy only, so a same-cycle pop never frees a slot early
   assign in_ready  = (count_q < CNT_W'(DEPTH));
   assign wb_valid  = (count_q != CNT_W'(0));
   assign wb_addr   = addr_q[rd_ptr_q];
   assign wb_data   = data_q[rd_ptr_q];
   assign flags     = flags_q;
   assign br_taken  = br_taken_q;
   assign br_target = br_target_q;

   always_comb begin
      accept      = in_valid & in_ready;
      push        = accept & in_wen;
      pop         = wb_valid & wb_ready;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      flags_d     = flags_q;
      br_taken_d  = 1'b0;
      br_target_d = br_target_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // A branch beat never writes flags, even with in_setf set
      if (accept && !in_br && in_setf) begin
         flags_d = in_szcv;
      end else begin
         flags_d = flags_q;
      end

      if (accept && in_br && cond_met(in_cond, flags_q[3], flags_q[2], flags_q[0])) begin
         br_taken_d  = 1'b1;
         br_target_d = in_target;
      end else begin
         br_taken_d  = 1'b0;
         br_target_d = br_target_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         flags_q     <= 4'b0000;
         br_taken_q  <= 1'b0;
         br_target_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         flags_q     <= flags_d;
         br_taken_q  <= br_taken_d;
         br_target_q <= br_target_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else if (push) begin
         addr_q[wr_ptr_q] <= in_rd;
         data_q[wr_ptr_q] <= in_res;
      end
   end

endmodule
